// File: rtl/mul_share_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_share_arbiter_if
//  Description : Requester-side and multiplier-side signals of the shared
//                multiplier arbiter, grouped with slave (arbiter) and
//                master (environment) views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] op_a;
    logic [NUM_REQ*16-1:0] op_b;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  busy;
    logic [15:0]           mul_a;
    logic [15:0]           mul_b;
    logic                  mul_en;
    logic [31:0]           mul_res;
    logic                  mul_ack;

    modport slave (
        input  req, op_a, op_b, mul_res, mul_ack,
        output gnt, rsp_valid, rsp_data, busy, mul_a, mul_b, mul_en
    );

    modport master (
        output req, op_a, op_b, mul_res, mul_ack,
        input  gnt, rsp_valid, rsp_data, busy, mul_a, mul_b, mul_en
    );
endinterface

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_share_arbiter
//  Description : Shares one sequential 16x16 multiplier among NUM_REQ
//                requesters with round-robin arbitration. Define
//                MUL_SHARE_FIXED_PRIO_EN for fixed (lowest index) priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  wire                clk,
    input  wire                rst,
    mul_share_arbiter_if.slave bus
);

    localparam int c_op_w  = 16;
    localparam int c_res_w = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    w_gnt_nxt;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [NUM_REQ-1:0]    w_rsp_valid_nxt;
    logic [c_res_w-1:0]    r_rsp_data;
    logic [c_res_w-1:0]    w_rsp_data_nxt;
    logic [c_op_w-1:0]     r_mul_a;
    logic [c_op_w-1:0]     w_mul_a_nxt;
    logic [c_op_w-1:0]     r_mul_b;
    logic [c_op_w-1:0]     w_mul_b_nxt;
    logic                  r_mul_en;
    logic                  w_mul_en_nxt;
    logic [PTR_W-1:0]      r_win;
    logic [PTR_W-1:0]      w_win_nxt;

    logic [PTR_W-1:0]      w_pick;
    logic                  w_found;

    logic [c_op_w-1:0]     w_op_a_arr [NUM_REQ];
    logic [c_op_w-1:0]     w_op_b_arr [NUM_REQ];

    // Unpack the flat operand buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_op_a_arr[gi] = bus.op_a[c_op_w*gi + c_op_w - 1 : c_op_w*gi];
        assign w_op_b_arr[gi] = bus.op_b[c_op_w*gi + c_op_w - 1 : c_op_w*gi];
    end

`ifdef MUL_SHARE_FIXED_PRIO_EN
    // Fixed priority: descending scan so the lowest set index is kept last.
    always_comb begin : p_pick
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[PTR_W'(k)]) begin
                w_pick  = PTR_W'(k);
                w_found = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0]      r_last;
    int                    w_idx;

    // Round-robin: first requester after the previous winner, with wrap.
    always_comb begin : p_pick
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && bus.req[PTR_W'(w_idx)]) begin
                w_pick  = PTR_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_last
        if (rst) begin
            r_last <= PTR_W'(NUM_REQ - 1);
        end else if (r_state == S_IDLE && w_found) begin
            r_last <= w_pick;
        end
    end
`endif

    always_comb begin : p_next
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_mul_en_nxt    = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_mul_a_nxt     = r_mul_a;
        w_mul_b_nxt     = r_mul_b;
        w_win_nxt       = r_win;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt    = NUM_REQ'(1) << w_pick;
                    w_mul_en_nxt = 1'b1;
                    w_mul_a_nxt  = w_op_a_arr[w_pick];
                    w_mul_b_nxt  = w_op_b_arr[w_pick];
                    w_win_nxt    = w_pick;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            // Operands stay put here: the multiplier reads them live.
            S_WAIT: begin
                if (bus.mul_ack) begin
                    w_rsp_data_nxt = bus.mul_res;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid_nxt = NUM_REQ'(1) << r_win;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : p_seq
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_en    <= 1'b0;
            r_win       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_mul_a     <= w_mul_a_nxt;
            r_mul_b     <= w_mul_b_nxt;
            r_mul_en    <= w_mul_en_nxt;
            r_win       <= w_win_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_en    = r_mul_en;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_arbiter
//  Description : Scoreboard bench for mul_share_arbiter with a behavioural
//                multiplier and a transaction-level arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(NREQ)) bif ();

    mul_share_arbiter #(.NUM_REQ(NREQ), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule
    function automatic int ref_pick(input logic [NREQ-1:0] r, input int last);
`ifdef MUL_SHARE_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (r[idx[1:0]]) return idx;
        end
`endif
        return 0;
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] prod;
    } exp_t;

    exp_t        sbq[$];
    int          gnt_log[$];
    logic [31:0] rsp_log[$];

    // Model state
    logic [NREQ-1:0]    p_req = '0;
    logic [NREQ*16-1:0] p_a   = '0;
    logic [NREQ*16-1:0] p_b   = '0;
    bit                 p_dec = 1'b0;
    int                 m_last = NREQ - 1;
    bit                 m_out  = 1'b0;
    logic [15:0]        m_a    = '0;
    logic [15:0]        m_b    = '0;
    bit                 m_ack_seen = 1'b0;
    int                 m_ack_cyc  = 0;
    int                 cyc        = 0;

    // Multiplier model
    logic spur    = 1'b0;
    int   lat_min = 1;
    int   lat_max = 4;

    initial begin : responder
        int cnt;
        cnt = 0;
        bif.mul_ack = 1'b0;
        bif.mul_res = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                bif.mul_ack = spur;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bif.mul_ack = 1'b1;
                    bif.mul_res = {16'b0, bif.mul_a} * {16'b0, bif.mul_b};
                end else begin
                    bif.mul_ack = spur;
                end
            end else begin
                bif.mul_ack = spur;
                if (spur) bif.mul_res = 32'hdead_beef;
                if (bif.mul_en) cnt = int'($urandom_range(lat_max, lat_min));
            end
        end
    end

    // Monitor / scoreboard: samples on the falling edge
    initial begin : monitor
        logic [NREQ-1:0] exp_g;
        int              w;
        exp_t            e;
        bit              rsp_now;
        logic [15:0]     a;
        logic [15:0]     b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_ctrl", {bif.gnt, bif.rsp_valid, bif.busy, bif.mul_en, bif.mul_a, bif.mul_b}, '0);
                chk("rst_data", bif.rsp_data, '0);
                sbq.delete();
                m_last = NREQ - 1;
                m_out = 1'b0;
                m_a = '0;
                m_b = '0;
                m_ack_seen = 1'b0;
                p_dec = 1'b0;
            end else begin
                exp_g = '0;
                if (p_dec && p_req != 0) begin
                    w = ref_pick(p_req, m_last);
                    exp_g = NREQ'(1) << w;
                    a = p_a[16*w +: 16];
                    b = p_b[16*w +: 16];
                    e.idx  = w;
                    e.prod = {16'b0, a} * {16'b0, b};
                    sbq.push_back(e);
                    m_last = w;
                    m_a = a;
                    m_b = b;
                    m_out = 1'b1;
                    m_ack_seen = 1'b0;
                end
                chk("gnt", bif.gnt, exp_g);
                if (bif.gnt != 0) begin
                    for (int i = 0; i < NREQ; i++) if (bif.gnt[i]) gnt_log.push_back(i);
                end
                chk("mul_en", bif.mul_en, exp_g != 0);
                chk("mul_a", bif.mul_a, m_a);
                chk("mul_b", bif.mul_b, m_b);
                rsp_now = m_out && m_ack_seen && (cyc == m_ack_cyc + 2);
                chk("rsp_strobe", bif.rsp_valid != 0, rsp_now);
                if (rsp_now && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rsp_valid", bif.rsp_valid, NREQ'(1) << e.idx);
                    chk("rsp_data", bif.rsp_data, e.prod);
                    rsp_log.push_back(bif.rsp_data);
                    m_out = 1'b0;
                    m_ack_seen = 1'b0;
                end
                chk("busy", bif.busy, m_out);
                if (m_out && exp_g == 0 && !m_ack_seen && bif.mul_ack) begin
                    m_ack_seen = 1'b1;
                    m_ack_cyc  = cyc;
                end
                p_dec = !m_out;
            end
            p_req = bif.req;
            p_a   = bif.op_a;
            p_b   = bif.op_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.req = '0;
        spur = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        gnt_log.delete();
        rsp_log.delete();
    endtask

    task automatic wait_gnts(input int n, input string nm);
        int k;
        k = 0;
        while (gnt_log.size() < n && k < 300) begin
            tick();
            k++;
        end
        if (gnt_log.size() < n) chk({nm, "_gnt_timeout"}, gnt_log.size(), n);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((m_out || sbq.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        if (m_out || sbq.size() != 0) chk({nm, "_drain_timeout"}, sbq.size(), 0);
        tick();
        tick();
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bif.op_a[16*i +: 16] = a;
        bif.op_b[16*i +: 16] = b;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int exp_four [5];
        int exp_pair [3];
        logic [31:0] exp_four_d [4];
`ifdef MUL_SHARE_FIXED_PRIO_EN
        exp_four   = '{0, 0, 0, 0, 0};
        exp_pair   = '{1, 1, 1};
        exp_four_d = '{32'd2, 32'd2, 32'd2, 32'd2};
`else
        exp_four   = '{0, 1, 2, 3, 0};
        exp_pair   = '{1, 3, 1};
        exp_four_d = '{32'd2, 32'd4, 32'd6, 32'd8};
`endif
        rst = 1'b1;
        bif.req  = '0;
        bif.op_a = '0;
        bif.op_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single request 3*5
        set_op(0, 16'd3, 16'd5);
        bif.req = 4'b0001;
        wait_gnts(1, "single");
        bif.req = '0;
        drain("single");
        if (gnt_log.size() > 0) chk("single_gnt_idx", gnt_log[0], 0);
        chk("single_rsp_cnt", rsp_log.size(), 1);
        if (rsp_log.size() > 0) chk("single_rsp_data", rsp_log[0], 32'd15);

        // All four requesting constantly
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd2);
        bif.req = 4'b1111;
        wait_gnts(5, "all4");
        bif.req = '0;
        drain("all4");
        for (int k = 0; k < 5; k++)
            if (k < gnt_log.size()) chk($sformatf("all4_gnt%0d", k), gnt_log[k], exp_four[k]);
        for (int k = 0; k < 4; k++)
            if (k < rsp_log.size()) chk($sformatf("all4_data%0d", k), rsp_log[k], exp_four_d[k]);

        // req=1010 from reset, requester 1 keeps asking
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i), 16'd1);
        bif.req = 4'b1010;
        wait_gnts(3, "pair");
        bif.req = '0;
        drain("pair");
        for (int k = 0; k < 3; k++)
            if (k < gnt_log.size()) chk($sformatf("pair_gnt%0d", k), gnt_log[k], exp_pair[k]);

        // Operand stability after grant
        do_reset();
        lat_min = 5;
        lat_max = 5;
        set_op(2, 16'd100, 16'd200);
        bif.req = 4'b0100;
        wait_gnts(1, "stable");
        bif.req = '0;
        set_op(2, 16'h1234, 16'h4321);
        tick();
        set_op(2, 16'hffff, 16'h0007);
        drain("stable");
        chk("stable_rsp_cnt", rsp_log.size(), 1);
        if (rsp_log.size() > 0) chk("stable_rsp_data", rsp_log[0], 32'd20000);

        // Spurious ack in IDLE
        do_reset();
        spur = 1'b1;
        repeat (5) tick();
        spur = 1'b0;
        repeat (3) tick();
        chk("spur_no_rsp", rsp_log.size(), 0);
        chk("spur_no_gnt", gnt_log.size(), 0);

        // Reset while waiting for the multiplier
        lat_min = 8;
        lat_max = 8;
        set_op(0, 16'd11, 16'd13);
        bif.req = 4'b0001;
        wait_gnts(1, "rstwait");
        bif.req = '0;
        repeat (3) tick();
        chk("rstwait_busy_before", bif.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstwait_async_ctrl", {bif.gnt, bif.rsp_valid, bif.busy, bif.mul_en, bif.mul_a, bif.mul_b}, '0);
        chk("rstwait_async_data", bif.rsp_data, '0);
        tick();
        tick();
        rst = 1'b0;
        gnt_log.delete();
        rsp_log.delete();
        lat_min = 1;
        lat_max = 4;
        repeat (10) tick();
        chk("rstwait_discarded", rsp_log.size(), 0);
        set_op(2, 16'd7, 16'd9);
        bif.req = 4'b0100;
        wait_gnts(1, "rstwait2");
        bif.req = '0;
        drain("rstwait2");
        if (gnt_log.size() > 0) chk("rstwait2_gnt_idx", gnt_log[0], 2);
        if (rsp_log.size() > 0) chk("rstwait2_data", rsp_log[0], 32'd63);
        chk("rstwait2_rsp_cnt", rsp_log.size(), 1);

        // Randomized traffic
        do_reset();
        lat_min = 1;
        lat_max = 6;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bif.req[i] && bif.gnt[i]) begin
                    bif.req[i] = ($urandom_range(3, 0) == 0);
                    set_op(i, 16'($urandom), 16'($urandom));
                end else if (!bif.req[i]) begin
                    set_op(i, 16'($urandom), 16'($urandom));
                    if ($urandom_range(7, 0) == 0) bif.req[i] = 1'b1;
                end
            end
            tick();
        end
        bif.req = '0;
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
